// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count and programmable almost-full/almost-empty flags.
// Optional sticky overflow/underflow reporting is built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
`endif
);

    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_AF   = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]   CNT_AE   = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [ADDR_W:0]   w_count_nxt;

    // A read may free the slot a same-cycle write needs, so full+rd+wr accepts both.
    assign w_rd_acc = rd_en & ~r_empty;
    assign w_wr_acc = wr_en & (~r_full | w_rd_acc);

    // Next occupancy from the accepted operations.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, read port and flags decoded from the next count so they track count exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr       <= PTR_ZERO;
            r_rd_ptr       <= PTR_ZERO;
            r_count        <= CNT_ZERO;
            r_rd_data      <= DATA_W'(0);
            r_rd_valid     <= 1'b0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= (CNT_ZERO >= CNT_AF);
            r_almost_empty <= (CNT_ZERO <= CNT_AE);
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_rd_valid     <= w_rd_acc;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == CNT_FULL);
            r_empty        <= (w_count_nxt == CNT_ZERO);
            r_almost_full  <= (w_count_nxt >= CNT_AF);
            r_almost_empty <= (w_count_nxt <= CNT_AE);
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags; a new event in the clearing cycle wins over err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (wr_en & ~w_wr_acc) | (r_overflow  & ~err_clr);
            r_underflow <= (rd_en & r_empty)   | (r_underflow & ~err_clr);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = DEPTH - 2;
    localparam int AE_LVL = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] wr_data = 8'h00;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0]        count;
`ifdef SYNC_FIFO_ERR_EN
    logic              overflow, underflow;
    logic              err_clr = 1'b0;
`endif

    sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count)
`ifdef SYNC_FIFO_ERR_EN
        , .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of stored words plus expected read-port and sticky-flag state.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_data = 8'h00;
    logic              m_valid = 1'b0;
    logic              m_ovf = 1'b0;
    logic              m_udf = 1'b0;

    task automatic model_reset();
        q.delete();
        m_data = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    // One clock with the given requests; model updated from the pre-edge occupancy.
    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
        bit was_empty, was_full, racc, wacc;
        wr_en = w; wr_data = d; rd_en = r;
`ifdef SYNC_FIFO_ERR_EN
        err_clr = c;
`endif
        @(posedge clk);
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        racc = r && !was_empty;
        wacc = w && (!was_full || racc);
        m_ovf = (w && !wacc) || (m_ovf && !c);
        m_udf = (r && was_empty) || (m_udf && !c);
        m_valid = racc;
        if (racc) m_data = q.pop_front();
        if (wacc) q.push_back(d);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
    endtask

    task automatic test_reset();
        #3;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0)
            begin errors++; $display("FAIL reset_state: count=%0d empty=%b full=%b, want 0/1/0", count, empty, full); end
        checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00)
            begin errors++; $display("FAIL reset_outputs: ae=%b af=%b rv=%b rd=%h, want 1/0/0/00", almost_empty, almost_full, rd_valid, rd_data); end
        for (int i = 0; i < 5; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h30 || count !== 5'd4)
            begin errors++; $display("FAIL pre_reset_read: rv=%b rd=%h count=%0d, want 1/30/4", rd_valid, rd_data, count); end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
        #2 reset = 1'b0;
        #1;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00 || almost_empty !== 1'b1)
            begin errors++; $display("FAIL async_reset: count=%0d empty=%b rv=%b rd=%h ae=%b, want 0/1/0/00/1", count, empty, rd_valid, rd_data, almost_empty); end
        wr_en = 1'b0; rd_en = 1'b0;
        #2 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            checks++; if (count !== 5'(i + 1) || almost_full !== ((i + 1) >= AF_LVL) || full !== ((i + 1) == DEPTH))
                begin errors++; $display("FAIL fill[%0d]: count=%0d af=%b full=%b", i, count, almost_full, full); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(i) || count !== 5'(DEPTH - 1 - i)
                          || almost_empty !== ((DEPTH - 1 - i) <= AE_LVL))
                begin errors++; $display("FAIL drain[%0d]: rv=%b rd=%h count=%0d ae=%b, want rd=%h", i, rd_valid, rd_data, count, almost_empty, 8'(i)); end
        end
        checks++; if (empty !== 1'b1 || full !== 1'b0)
            begin errors++; $display("FAIL drain_end: empty=%b full=%b, want 1/0", empty, full); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (rd_data !== m_data || rd_valid !== 1'b1)
                begin errors++; $display("FAIL wrap_pre[%0d]: rd=%h rv=%b, want %h/1", i, rd_data, rd_valid, m_data); end
        end
        for (int i = 0; i < 12; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        checks++; if (count !== 5'd12)
            begin errors++; $display("FAIL wrap_count: count=%0d, want 12", count); end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (rd_data !== 8'hA0 + 8'(i) || rd_valid !== 1'b1)
                begin errors++; $display("FAIL wrap_read[%0d]: rd=%h rv=%b, want %h/1", i, rd_data, rd_valid, 8'hA0 + 8'(i)); end
        end
        checks++; if (count !== 5'd0 || empty !== 1'b1)
            begin errors++; $display("FAIL wrap_end: count=%0d empty=%b, want 0/1", count, empty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        checks++; if (count !== 5'd16 || full !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 8'h10)
            begin errors++; $display("FAIL simul_full: count=%0d full=%b rv=%b rd=%h, want 16/1/1/10", count, full, rv_str(rd_valid), rd_data); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (rd_data !== m_data)
                begin errors++; $display("FAIL simul_drain[%0d]: rd=%h, want %h", i, rd_data, m_data); end
        end
        checks++; if (rd_data !== 8'h55 || empty !== 1'b1)
            begin errors++; $display("FAIL simul_last: rd=%h empty=%b, want 55/1", rd_data, empty); end
        step(1'b1, 8'h77, 1'b1, 1'b0);
        checks++; if (count !== 5'd1 || rd_valid !== 1'b0 || rd_data !== 8'h55 || empty !== 1'b0)
            begin errors++; $display("FAIL simul_empty: count=%0d rv=%b rd=%h empty=%b, want 1/0/55/0", count, rd_valid, rd_data, empty); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (rd_data !== 8'h77 || rd_valid !== 1'b1 || count !== 5'd0)
            begin errors++; $display("FAIL simul_empty_read: rd=%h rv=%b count=%0d, want 77/1/0", rd_data, rd_valid, count); end
    endtask

    function automatic logic rv_str(input logic v);
        return v;
    endfunction

    task automatic test_boundary();
`ifdef SYNC_FIFO_ERR_EN
        step(1'b0, 8'h00, 1'b0, 1'b1);
`endif
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        checks++; if (count !== 5'd16 || full !== 1'b1)
            begin errors++; $display("FAIL drop_full: count=%0d full=%b, want 16/1", count, full); end
`ifdef SYNC_FIFO_ERR_EN
        checks++; if (overflow !== 1'b1 || underflow !== 1'b0)
            begin errors++; $display("FAIL overflow_set: ovf=%b udf=%b, want 1/0", overflow, underflow); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (rd_data !== 8'hC0 + 8'(i))
                begin errors++; $display("FAIL drop_contents[%0d]: rd=%h, want %h", i, rd_data, 8'hC0 + 8'(i)); end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'hCF || count !== 5'd0)
            begin errors++; $display("FAIL drop_empty: rv=%b rd=%h count=%0d, want 0/CF/0", rd_valid, rd_data, count); end
`ifdef SYNC_FIFO_ERR_EN
        checks++; if (underflow !== 1'b1 || overflow !== 1'b1)
            begin errors++; $display("FAIL underflow_set: ovf=%b udf=%b, want 1/1", overflow, underflow); end
        step(1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (underflow !== 1'b1 || overflow !== 1'b0)
            begin errors++; $display("FAIL clear_priority: ovf=%b udf=%b, want 0/1", overflow, underflow); end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (underflow !== 1'b0 || overflow !== 1'b0)
            begin errors++; $display("FAIL err_clr: ovf=%b udf=%b, want 0/0", overflow, underflow); end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            int bias;
            bias = (n / 100) % 2 == 0 ? 70 : 30;
            step(($urandom_range(0, 99) < bias), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < 100 - bias), ($urandom_range(0, 19) == 0));
            checks++; if (int'(count) != q.size() || rd_valid !== m_valid || rd_data !== m_data)
                begin errors++; $display("FAIL rand_data[%0d]: count=%0d rv=%b rd=%h, want %0d/%b/%h", n, count, rd_valid, rd_data, q.size(), m_valid, m_data); end
            checks++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)
                          || almost_full !== (q.size() >= AF_LVL) || almost_empty !== (q.size() <= AE_LVL))
                begin errors++; $display("FAIL rand_flags[%0d]: e=%b f=%b af=%b ae=%b size=%0d", n, empty, full, almost_full, almost_empty, q.size()); end
`ifdef SYNC_FIFO_ERR_EN
            checks++; if (overflow !== m_ovf || underflow !== m_udf)
                begin errors++; $display("FAIL rand_err[%0d]: ovf=%b udf=%b, want %b/%b", n, overflow, underflow, m_ovf, m_udf); end
`endif
        end
    endtask

    initial begin
        #17 reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        @(posedge clk); #1;
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_boundary();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
